wf68k_divider_pipe: RTL and testbench
=====================================

Name: wf68k_divider_pipe

Overview:
- Parametrised successor to the core's single-radix division engine: a restoring divider with generic operand width and 1/2/4 quotient bits retired per cycle.
- Supports signed/unsigned and single/double-width dividend modes, start/done handshake, abort, and early overflow and divide-by-zero exits.
- Sits beside the ALU; serves DIVU/DIVS (word, long, 64/32) and any future coprocessor divide path.

Parameters:
- DATA_W, 32, divisor/quotient/remainder width; even; DATA_W % RADIX_BITS == 0.
- RADIX_BITS, 1, quotient bits per CALC cycle; legal values 1, 2, 4.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request; accepted only in IDLE.
- ABORT  in  1  cancel current operation.
- SIGNED_OP  in  1  1 = two's-complement operands.
- LONG_DIVIDEND  in  1  1 = dividend {DIVIDEND_HI,DIVIDEND_LO}; 0 = DIVIDEND_LO only.
- DIVIDEND_HI  in  DATA_W  upper dividend half (also restore value).
- DIVIDEND_LO  in  DATA_W  lower dividend half (also restore value).
- DIVISOR  in  DATA_W  divisor.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle result-valid pulse.
- QUOTIENT  out  DATA_W  quotient.
- REMAINDER  out  DATA_W  remainder.
- DIV_ZERO  out  1  divisor was zero.
- OVERFLOW  out  1  quotient does not fit in DATA_W.

Behaviour:
- Interface: one clock CLK; RESET synchronous, active-high.
- Reset: state IDLE; BUSY, DONE, DIV_ZERO, OVERFLOW, QUOTIENT, REMAINDER all 0. RESET overrides START/ABORT in the same cycle and mid-operation.
- States: IDLE, INIT, CALC, SIGN.
- IDLE:
  - START=1 captures all operand and mode inputs; next state INIT; BUSY=1 from the next cycle.
  - Inputs are ignored after capture.
  - START while BUSY is ignored, no queuing.
- INIT:
  - Form N-bit magnitude of the dividend: N = 2*DATA_W if LONG_DIVIDEND, else DATA_W. In 32-bit mode, sign-extend DIVIDEND_LO when signed.
  - Form magnitude of the divisor and record result signs.
  - Divisor == 0: DIV_ZERO=1, QUOTIENT=DIVIDEND_LO, REMAINDER=DIVIDEND_HI, DONE, go to IDLE.
  - Else, LONG mode with |dividend| upper half >= |divisor|: OVERFLOW=1, same restore values, DONE, go to IDLE.
  - Else go to CALC with K = N/RADIX_BITS iterations.
- CALC:
  - Each cycle shifts RADIX_BITS dividend bits (MSB first) into the partial remainder.
  - Performs RADIX_BITS compare/subtract steps, appending a quotient bit per step.
  - Partial remainder is DATA_W+1 bits wide; no intermediate overflow.
  - After K cycles go to SIGN.
- SIGN:
  - Quotient negated iff signed and dividend sign != divisor sign. Remainder takes the dividend sign (68k semantics).
  - Overflow if the unsigned magnitude quotient is >= 2^DATA_W. For signed: overflow if a positive quotient is > 2^(DATA_W-1)-1, or a negative quotient's magnitude is > 2^(DATA_W-1).
  - On overflow: OVERFLOW=1, QUOTIENT=DIVIDEND_LO, REMAINDER=DIVIDEND_HI.
  - Register results, DONE=1 next cycle, return to IDLE.
- Latency, START high at cycle 0:
  - Normal: DONE at cycle K+3.
  - Early exits: DONE at cycle 2.
- BUSY is high from cycle 1 through the DONE cycle.
- DONE and BUSY fall together in the cycle after DONE.
- DIV_ZERO and OVERFLOW clear on the next accepted START and hold until then. QUOTIENT and REMAINDER hold until the next DONE.
- ABORT in INIT/CALC/SIGN: next state IDLE, BUSY=0, no DONE, outputs unchanged. ABORT in IDLE has no effect. ABORT has priority over the completion of the same cycle.

Optional Feature:
- Macro: WF68K_DIV_EARLY_OUT_EN.
- Defined:
  - INIT counts leading zeros of |dividend| (N bits), rounded down to a multiple of RADIX_BITS.
  - CALC pre-skips those positions, so K = max(1, (N - lz)/RADIX_BITS).
  - Latency becomes data-dependent; results are bit-identical.
- Undefined: K is fixed as above and the leading-zero logic is absent.

Test Plan (DATA_W=32, RADIX_BITS=1, macro undefined unless stated):
- Unsigned 32-bit: 100 / 7 -> QUOTIENT=14, REMAINDER=2, DONE at cycle 35, flags 0.
- Signed 32-bit: -7 / 2 -> QUOTIENT=0xFFFFFFFD, REMAINDER=0xFFFFFFFF.
- Divide by zero: HI=0xAAAA0000, LO=0x12345678, divisor 0 -> DIV_ZERO=1, QUOTIENT=0x12345678, REMAINDER=0xAAAA0000, DONE at cycle 2.
- Long unsigned: HI=5, LO=0, divisor 5 -> early OVERFLOW at cycle 2, QUOTIENT=0, REMAINDER=5.
- Signed 32-bit: 0x80000000 / 0xFFFFFFFF, HI=0 -> OVERFLOW=1 at cycle 35, QUOTIENT=0x80000000, REMAINDER=0.
- ABORT at cycle 10, then START 9/3 next cycle -> no DONE for the first operation; second yields Q=3, R=0. Repeat with RESET mid-CALC -> all outputs 0.
- With WF68K_DIV_EARLY_OUT_EN, 100 / 7 -> same results, DONE at cycle 10 (lz=25, K=7).

Source files
------------

// File: rtl/wf68k_divider_pipe.sv
// ---------------------------------------------------------------------------------------------
// wf68k_divider_pipe
//
// Restoring divider with a parametrised operand width that retires RADIX_BITS quotient bits
// per CALC cycle. It handles signed/unsigned operands, single- or double-width dividends,
// abort, and early exits for divide-by-zero and guaranteed overflow. Serves DIVU/DIVS
// (word, long, 64/32) beside the ALU.
//
// Optional feature: define WF68K_DIV_EARLY_OUT_EN to skip the leading zero bits of the
// dividend magnitude, which makes latency data dependent. Results are bit-identical.
//
// Parameters:
//   DATA_W        divisor/quotient/remainder width (even, multiple of RADIX_BITS)
//   RADIX_BITS    quotient bits per CALC cycle: 1, 2 or 4
//
// Ports:
//   CLK            clock, rising edge
//   RESET          synchronous active-high reset
//   START          request, accepted only when idle and not busy
//   ABORT          cancel the operation in flight
//   SIGNED_OP      1 = two's-complement operands
//   LONG_DIVIDEND  1 = dividend {DIVIDEND_HI, DIVIDEND_LO}, 0 = DIVIDEND_LO only
//   DIVIDEND_HI    upper dividend half (restored to REMAINDER on error exits)
//   DIVIDEND_LO    lower dividend half (restored to QUOTIENT on error exits)
//   DIVISOR        divisor
//   BUSY           operation in progress, high from the cycle after START through DONE
//   DONE           one-cycle result-valid pulse
//   QUOTIENT       quotient, held until the next DONE
//   REMAINDER      remainder (sign of the dividend), held until the next DONE
//   DIV_ZERO       divisor was zero, held until the next accepted START
//   OVERFLOW       quotient does not fit DATA_W, held until the next accepted START
// ---------------------------------------------------------------------------------------------
module wf68k_divider_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RADIX_BITS = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              ABORT,
    input  logic              SIGNED_OP,
    input  logic              LONG_DIVIDEND,
    input  logic [DATA_W-1:0] DIVIDEND_HI,
    input  logic [DATA_W-1:0] DIVIDEND_LO,
    input  logic [DATA_W-1:0] DIVISOR,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] QUOTIENT,
    output logic [DATA_W-1:0] REMAINDER,
    output logic              DIV_ZERO,
    output logic              OVERFLOW
);

    localparam int unsigned DblW     = 2 * DATA_W;
    localparam int unsigned CntW     = $clog2(DblW / RADIX_BITS + 1);
    localparam int unsigned LenW     = $clog2(DblW + 1);
    localparam int unsigned RadixLog = $clog2(RADIX_BITS);

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StCalc,
        StSign
    } state_e;

    state_e state_q, state_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;

    // Operands and mode captured on START
    logic              op_sgn_q, op_sgn_d;
    logic              op_long_q, op_long_d;
    logic [DATA_W-1:0] op_hi_q, op_hi_d;
    logic [DATA_W-1:0] op_lo_q, op_lo_d;
    logic [DATA_W-1:0] op_div_q, op_div_d;

    // Iteration datapath
    logic [DblW-1:0]   dvd_q, dvd_d;    // dividend magnitude, MSB-aligned, shifted out MSB first
    logic [DATA_W-1:0] dvs_q, dvs_d;    // divisor magnitude
    logic [DATA_W-1:0] prem_q, prem_d;  // partial remainder (always < divisor between cycles)
    logic [DATA_W-1:0] qacc_q, qacc_d;  // quotient magnitude accumulator
    logic [CntW-1:0]   cnt_q, cnt_d;    // CALC cycles left

    // -----------------------------------------------------------------------------------------
    // Operand preparation (evaluated from captured operands, used in INIT and SIGN)
    // -----------------------------------------------------------------------------------------
    logic              dvd_neg;
    logic              dvs_neg;
    logic [DblW-1:0]   long_val;
    logic [DATA_W-1:0] short_mag;
    logic [DblW-1:0]   dvd_mag;
    logic [DATA_W-1:0] dvs_mag;
    logic [LenW-1:0]   n_len;
    logic              early_ovf;
    logic [DblW-1:0]   init_dvd;
    logic [CntW-1:0]   init_cnt;
`ifdef WF68K_DIV_EARLY_OUT_EN
    logic [LenW-1:0]   lz;
    logic              lz_found;
`endif

    always_comb begin : prep_comb
        dvd_neg   = op_sgn_q & (op_long_q ? op_hi_q[DATA_W-1] : op_lo_q[DATA_W-1]);
        dvs_neg   = op_sgn_q & op_div_q[DATA_W-1];
        long_val  = {op_hi_q, op_lo_q};
        short_mag = dvd_neg ? -op_lo_q : op_lo_q;
        if (op_long_q) begin
            dvd_mag = dvd_neg ? -long_val : long_val;
            n_len   = LenW'(DblW);
        end else begin
            // Short dividend is left-aligned so CALC always consumes from bit DblW-1
            dvd_mag = {short_mag, {DATA_W{1'b0}}};
            n_len   = LenW'(DATA_W);
        end
        dvs_mag = dvs_neg ? -op_div_q : op_div_q;

        // Upper half >= divisor means the quotient magnitude needs more than DATA_W bits.
        // Passing this check also guarantees the unsigned quotient fits in qacc.
        early_ovf = op_long_q && (dvd_mag[DblW-1:DATA_W] >= dvs_mag);

`ifdef WF68K_DIV_EARLY_OUT_EN
        lz       = '0;
        lz_found = 1'b0;
        for (int i = DblW - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (dvd_mag[i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz = lz + LenW'(1);
                end
            end
        end
        if (lz > n_len) begin
            lz = n_len;
        end
        lz = lz & ~LenW'(RADIX_BITS - 1);
        // Keep at least one CALC cycle, even for a zero dividend
        if (lz > n_len - LenW'(RADIX_BITS)) begin
            lz = n_len - LenW'(RADIX_BITS);
        end
        init_dvd = dvd_mag << lz;
        init_cnt = CntW'((n_len - lz) >> RadixLog);
`else
        init_dvd = dvd_mag;
        init_cnt = CntW'(n_len >> RadixLog);
`endif
    end

    // -----------------------------------------------------------------------------------------
    // One CALC cycle: RADIX_BITS restoring compare/subtract steps
    // -----------------------------------------------------------------------------------------
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] step_rem;
    logic [DblW-1:0]   step_dvd;
    logic [DATA_W-1:0] step_quo;

    always_comb begin : calc_comb
        step_rem = prem_q;
        step_dvd = dvd_q;
        step_quo = qacc_q;
        trial    = '0;
        for (int unsigned s = 0; s < RADIX_BITS; s++) begin
            // DATA_W+1 bits: remainder < divisor, so the shifted value cannot overflow
            trial    = {step_rem, step_dvd[DblW-1]};
            step_dvd = step_dvd << 1;
            if (trial >= {1'b0, dvs_q}) begin
                trial    = trial - {1'b0, dvs_q};
                step_quo = {step_quo[DATA_W-2:0], 1'b1};
            end else begin
                step_quo = {step_quo[DATA_W-2:0], 1'b0};
            end
            step_rem = trial[DATA_W-1:0];
        end
    end

    // -----------------------------------------------------------------------------------------
    // Sign fix-up and signed range check
    // -----------------------------------------------------------------------------------------
    logic              quo_neg;
    logic              fin_ovf;
    logic [DATA_W-1:0] fin_quo;
    logic [DATA_W-1:0] fin_rem;

    always_comb begin : sign_comb
        quo_neg = dvd_neg ^ dvs_neg;
        fin_ovf = 1'b0;
        if (op_sgn_q) begin
            // Positive limit 2^(W-1)-1; negative magnitude limit 2^(W-1)
            fin_ovf = quo_neg ? (qacc_q[DATA_W-1] & (|qacc_q[DATA_W-2:0])) : qacc_q[DATA_W-1];
        end
        fin_quo = quo_neg ? -qacc_q : qacc_q;
        // Remainder follows the dividend sign
        fin_rem = dvd_neg ? -prem_q : prem_q;
    end

    // -----------------------------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------------------------
    always_comb begin : fsm_comb
        state_d   = state_q;
        busy_d    = busy_q & ~done_q;  // BUSY drops together with DONE
        done_d    = 1'b0;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        op_sgn_d  = op_sgn_q;
        op_long_d = op_long_q;
        op_hi_d   = op_hi_q;
        op_lo_d   = op_lo_q;
        op_div_d  = op_div_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        qacc_d    = qacc_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                // The DONE cycle sits in IDLE with BUSY still high, so START is ignored there
                if (START && !busy_q) begin
                    op_sgn_d  = SIGNED_OP;
                    op_long_d = LONG_DIVIDEND;
                    op_hi_d   = DIVIDEND_HI;
                    op_lo_d   = DIVIDEND_LO;
                    op_div_d  = DIVISOR;
                    dz_d      = 1'b0;
                    ovf_d     = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StInit;
                end
            end

            StInit: begin
                if (ABORT) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (op_div_q == '0) begin
                    dz_d    = 1'b1;
                    quo_d   = op_lo_q;
                    rem_d   = op_hi_q;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (early_ovf) begin
                    ovf_d   = 1'b1;
                    quo_d   = op_lo_q;
                    rem_d   = op_hi_q;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    dvd_d   = init_dvd;
                    dvs_d   = dvs_mag;
                    prem_d  = '0;
                    qacc_d  = '0;
                    cnt_d   = init_cnt;
                    state_d = StCalc;
                end
            end

            StCalc: begin
                if (ABORT) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    dvd_d  = step_dvd;
                    prem_d = step_rem;
                    qacc_d = step_quo;
                    cnt_d  = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = StSign;
                    end
                end
            end

            StSign: begin
                if (ABORT) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    if (fin_ovf) begin
                        ovf_d = 1'b1;
                        quo_d = op_lo_q;
                        rem_d = op_hi_q;
                    end else begin
                        quo_d = fin_quo;
                        rem_d = fin_rem;
                    end
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            op_sgn_q  <= 1'b0;
            op_long_q <= 1'b0;
            op_hi_q   <= '0;
            op_lo_q   <= '0;
            op_div_q  <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            qacc_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            op_sgn_q  <= op_sgn_d;
            op_long_q <= op_long_d;
            op_hi_q   <= op_hi_d;
            op_lo_q   <= op_lo_d;
            op_div_q  <= op_div_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            qacc_q    <= qacc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign QUOTIENT  = quo_q;
    assign REMAINDER = rem_q;
    assign DIV_ZERO  = dz_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_wf68k_divider_pipe.sv
// ---------------------------------------------------------------------------------------------
// Bench for wf68k_divider_pipe (DATA_W=32, RADIX_BITS=1). Directed cases plus randomised
// operations compared against an arithmetic reference model (64-bit / and %). Honours
// WF68K_DIV_EARLY_OUT_EN for the expected latency.
// ---------------------------------------------------------------------------------------------
module tb_wf68k_divider_pipe;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic        ABORT;
    logic        SIGNED_OP;
    logic        LONG_DIVIDEND;
    logic [31:0] DIVIDEND_HI;
    logic [31:0] DIVIDEND_LO;
    logic [31:0] DIVISOR;
    logic        BUSY;
    logic        DONE;
    logic [31:0] QUOTIENT;
    logic [31:0] REMAINDER;
    logic        DIV_ZERO;
    logic        OVERFLOW;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] last_q;
    logic [31:0] last_r;

    always #5 CLK = ~CLK;

    wf68k_divider_pipe #(
        .DATA_W    (32),
        .RADIX_BITS(1)
    ) u_dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .START        (START),
        .ABORT        (ABORT),
        .SIGNED_OP    (SIGNED_OP),
        .LONG_DIVIDEND(LONG_DIVIDEND),
        .DIVIDEND_HI  (DIVIDEND_HI),
        .DIVIDEND_LO  (DIVIDEND_LO),
        .DIVISOR      (DIVISOR),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .QUOTIENT     (QUOTIENT),
        .REMAINDER    (REMAINDER),
        .DIV_ZERO     (DIV_ZERO),
        .OVERFLOW     (OVERFLOW)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: 68k divide semantics from plain 64-bit arithmetic
    task automatic ref_div(input logic s, input logic l, input logic [31:0] hi,
                           input logic [31:0] lo, input logic [31:0] dv,
                           output logic [31:0] eq, output logic [31:0] er,
                           output logic edz, output logic eovf, output int elat);
        logic [63:0] dm, vm, qm, rm;
        logic        dneg, vneg, qneg, too_big;
        int          n, sig;
        edz  = 1'b0;
        eovf = 1'b0;
        if (l) dm = {hi, lo};
        else   dm = s ? {{32{lo[31]}}, lo} : {32'd0, lo};
        dneg = s && dm[63];
        if (dneg) dm = 64'd0 - dm;
        vneg = s && dv[31];
        vm   = vneg ? (64'd1 << 32) - {32'd0, dv} : {32'd0, dv};
        if (dv == 32'd0) begin
            edz  = 1'b1;
            eq   = lo;
            er   = hi;
            elat = 2;
            return;
        end
        qm      = dm / vm;
        rm      = dm % vm;
        qneg    = s && (dneg != vneg);
        too_big = qm >= (64'd1 << 32);
        eovf    = too_big || (s && (qneg ? qm > 64'h8000_0000 : qm > 64'h7FFF_FFFF));
        if (eovf) begin
            eq = lo;
            er = hi;
        end else begin
            eq = qm[31:0];
            if (qneg) eq = -eq;
            er = rm[31:0];
            if (dneg) er = -er;
        end
        n = l ? 64 : 32;
        if (l && too_big) begin
            elat = 2;
        end else begin
`ifdef WF68K_DIV_EARLY_OUT_EN
            sig = 0;
            for (int b = 0; b < n; b++) if (dm[b]) sig = b + 1;
            elat = ((sig < 1) ? 1 : sig) + 3;
`else
            sig  = n;
            elat = sig + 3;
`endif
        end
    endtask

    // Present an operation for one clock edge, then scramble the operand inputs
    task automatic launch(input logic s, input logic l, input logic [31:0] hi,
                          input logic [31:0] lo, input logic [31:0] dv);
        SIGNED_OP     = s;
        LONG_DIVIDEND = l;
        DIVIDEND_HI   = hi;
        DIVIDEND_LO   = lo;
        DIVISOR       = dv;
        START         = 1'b1;
        @(posedge CLK);
        #1;
        START         = 1'b0;
        SIGNED_OP     = 1'($urandom);
        LONG_DIVIDEND = 1'($urandom);
        DIVIDEND_HI   = $urandom;
        DIVIDEND_LO   = $urandom;
        DIVISOR       = $urandom;
    endtask

    task automatic wait_done(input string tag, input int start, output int lat);
        lat = start;
        while (DONE !== 1'b1 && lat < 200) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check_eq({tag, ".done"}, 64'(DONE), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic s, input logic l,
                          input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] dv);
        logic [31:0] eq, er;
        logic        edz, eovf;
        int          elat, lat;
        ref_div(s, l, hi, lo, dv, eq, er, edz, eovf, elat);
        launch(s, l, hi, lo, dv);
        wait_done(tag, 1, lat);
        check_eq({tag, ".lat"}, 64'(lat), 64'(elat));
        check_eq({tag, ".q"}, 64'(QUOTIENT), 64'(eq));
        check_eq({tag, ".r"}, 64'(REMAINDER), 64'(er));
        check_eq({tag, ".dz"}, 64'(DIV_ZERO), 64'(edz));
        check_eq({tag, ".ovf"}, 64'(OVERFLOW), 64'(eovf));
        check_eq({tag, ".busy"}, 64'(BUSY), 64'd1);
        @(posedge CLK);
        #1;
        check_eq({tag, ".busy_fall"}, 64'(BUSY), 64'd0);
        check_eq({tag, ".done_fall"}, 64'(DONE), 64'd0);
        check_eq({tag, ".q_hold"}, 64'(QUOTIENT), 64'(eq));
        last_q = eq;
        last_r = er;
    endtask

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] eq, er, hi, lo, dv;
        logic        edz, eovf, s, l;
        int          elat, lat, dones;

        RESET = 1'b1; START = 1'b0; ABORT = 1'b0; SIGNED_OP = 1'b0; LONG_DIVIDEND = 1'b0;
        DIVIDEND_HI = '0; DIVIDEND_LO = '0; DIVISOR = '0;
        step_cycles(3);
        check_eq("rst.busy", 64'(BUSY), 64'd0);
        check_eq("rst.done", 64'(DONE), 64'd0);
        check_eq("rst.q", 64'(QUOTIENT), 64'd0);
        check_eq("rst.r", 64'(REMAINDER), 64'd0);
        check_eq("rst.dz", 64'(DIV_ZERO), 64'd0);
        check_eq("rst.ovf", 64'(OVERFLOW), 64'd0);
        RESET = 1'b0;
        step_cycles(1);

        // Directed cases
        run_op("u100_7", 1'b0, 1'b0, 32'd0, 32'd100, 32'd7);
        run_op("s_m7_2", 1'b1, 1'b0, 32'd0, 32'hFFFF_FFF9, 32'd2);
        run_op("dz", 1'b0, 1'b0, 32'hAAAA_0000, 32'h1234_5678, 32'd0);
        step_cycles(3);
        check_eq("dz.hold", 64'(DIV_ZERO), 64'd1);
        run_op("long_ovf", 1'b0, 1'b1, 32'd5, 32'd0, 32'd5);
        run_op("s_min_m1", 1'b1, 1'b0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("s_long", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'd3);

        // ABORT in CALC at cycle 10, new START in cycle 11
        launch(1'b0, 1'b0, 32'd0, 32'd100, 32'd7);
        step_cycles(9);
        ABORT = 1'b1;
        @(posedge CLK);
        #1;
        ABORT = 1'b0;
        check_eq("abort.busy", 64'(BUSY), 64'd0);
        check_eq("abort.done", 64'(DONE), 64'd0);
        check_eq("abort.q", 64'(QUOTIENT), 64'(last_q));
        check_eq("abort.r", 64'(REMAINDER), 64'(last_r));
        run_op("after_abort", 1'b0, 1'b0, 32'd0, 32'd9, 32'd3);

        // START while busy is ignored
        ref_div(1'b0, 1'b0, 32'd0, 32'd100, 32'd7, eq, er, edz, eovf, elat);
        launch(1'b0, 1'b0, 32'd0, 32'd100, 32'd7);
        step_cycles(4);
        SIGNED_OP = 1'b0; LONG_DIVIDEND = 1'b0; DIVIDEND_LO = 32'd9; DIVISOR = 32'd3;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done("busy_start", 6, lat);
        check_eq("busy_start.lat", 64'(lat), 64'(elat));
        check_eq("busy_start.q", 64'(QUOTIENT), 64'(eq));
        check_eq("busy_start.r", 64'(REMAINDER), 64'(er));
        step_cycles(1);

        // RESET mid-CALC clears everything and no DONE follows
        launch(1'b0, 1'b0, 32'd0, 32'd100, 32'd7);
        step_cycles(9);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check_eq("midrst.busy", 64'(BUSY), 64'd0);
        check_eq("midrst.done", 64'(DONE), 64'd0);
        check_eq("midrst.q", 64'(QUOTIENT), 64'd0);
        check_eq("midrst.r", 64'(REMAINDER), 64'd0);
        check_eq("midrst.dz", 64'(DIV_ZERO), 64'd0);
        check_eq("midrst.ovf", 64'(OVERFLOW), 64'd0);
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1) dones++;
        end
        check_eq("midrst.no_done", 64'(dones), 64'd0);

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            s  = 1'($urandom);
            l  = 1'($urandom);
            hi = $urandom;
            lo = $urandom;
            dv = $urandom;
            case ($urandom_range(0, 7))
                0:       dv = 32'd0;
                1, 2:    dv = dv >> $urandom_range(16, 31);
                default: ;
            endcase
            if (l && $urandom_range(0, 3) != 0) begin
                hi = hi >> $urandom_range(4, 31);
                if (s && $urandom_range(0, 1) == 1) hi = ~hi;
            end
            run_op($sformatf("rnd%0d", i), s, l, hi, lo, dv);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
